icache_miss_entry_ctrl: RTL

- Allocation and sequencing controller for the instruction-cache miss entry table (NUM_ENTRY slots).
- Tracks per-entry state (FREE/PEND/WAIT). New misses take the lowest free slot; a secondary miss to an in-flight block address merges into its existing entry.
- Issues one memory request per entry in lowest-index order and frees the entry on refill release.
- Sits between the icache miss path and the L2/memory request port.

---
 rtl/icache_miss_entry_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/icache_miss_entry_ctrl.sv
// Miss entry table for the icache: allocates and merges misses, issues one memory
// request per entry in lowest-index order, and frees entries on refill release.
module icache_miss_entry_ctrl #(
  parameter int unsigned NUM_ENTRY   = 4,
  parameter int unsigned ENTRY_DEPTH = 2,
  parameter int unsigned BA_BITS     = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_valid_i,
  input  logic [BA_BITS-1:0]     alloc_addr_i,
  output logic                   alloc_ready_o,
  output logic                   alloc_hit_o,
  output logic [ENTRY_DEPTH-1:0] alloc_idx_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [BA_BITS-1:0]     mem_req_addr_o,
  output logic [ENTRY_DEPTH-1:0] mem_req_idx_o,
  input  logic                   rel_valid_i,
  input  logic [ENTRY_DEPTH-1:0] rel_idx_i,
  output logic                   full_o,
  output logic [ENTRY_DEPTH:0]   used_o
);

  typedef enum logic [1:0] {EntFree, EntPend, EntWait} ent_st_e;
  typedef enum logic {StIdle, StReq} iss_st_e;

  ent_st_e            ent_q  [NUM_ENTRY];
  logic [BA_BITS-1:0] addr_q [NUM_ENTRY];
  iss_st_e            iss_q;

  logic                   hit;
  logic [ENTRY_DEPTH-1:0] hit_idx;
  logic [ENTRY_DEPTH-1:0] free_idx;
  logic                   any_pend;
  logic [ENTRY_DEPTH-1:0] pend_idx;
  logic [ENTRY_DEPTH:0]   used;
  logic                   fire_new;
  logic                   handshake;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    any_pend = 1'b0;
    pend_idx = '0;
    used     = '0;
    for (int k = NUM_ENTRY - 1; k >= 0; k--) begin
      if (ent_q[k] != EntFree && addr_q[k] == alloc_addr_i &&
          !(rel_valid_i && rel_idx_i == ENTRY_DEPTH'(k))) begin
        hit     = 1'b1;
        hit_idx = ENTRY_DEPTH'(k);
      end
      if (ent_q[k] == EntFree) begin
        free_idx = ENTRY_DEPTH'(k);
      end else begin
        used += {{ENTRY_DEPTH{1'b0}}, 1'b1};
      end
      if (ent_q[k] == EntPend) begin
        any_pend = 1'b1;
        pend_idx = ENTRY_DEPTH'(k);
      end
    end
  end

  always_comb begin
    used_o        = used;
    full_o        = (used == (ENTRY_DEPTH + 1)'(NUM_ENTRY));
    alloc_hit_o   = hit;
    alloc_ready_o = hit | ~full_o;
    alloc_idx_o   = hit ? hit_idx : free_idx;
    fire_new      = alloc_valid_i & ~hit & ~full_o;
    handshake     = (iss_q == StReq) & mem_req_ready_i;
  end

  // Alloc, issue and release act on entries in FREE, PEND and WAIT respectively,
  // so the three updates never collide on one entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_ENTRY; k++) begin
        ent_q[k]  <= EntFree;
        addr_q[k] <= '0;
      end
      iss_q           <= StIdle;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
      mem_req_idx_o   <= '0;
    end else begin
      for (int k = 0; k < NUM_ENTRY; k++) begin
        if (fire_new && free_idx == ENTRY_DEPTH'(k)) begin
          ent_q[k]  <= EntPend;
          addr_q[k] <= alloc_addr_i;
        end else if (handshake && mem_req_idx_o == ENTRY_DEPTH'(k)) begin
          ent_q[k] <= EntWait;
        end else if (rel_valid_i && rel_idx_i == ENTRY_DEPTH'(k) && ent_q[k] == EntWait) begin
          ent_q[k] <= EntFree;
        end
      end
      case (iss_q)
        StIdle: begin
          if (any_pend) begin
            iss_q           <= StReq;
            mem_req_valid_o <= 1'b1;
            mem_req_idx_o   <= pend_idx;
            mem_req_addr_o  <= addr_q[pend_idx];
          end
        end
        StReq: begin
          if (mem_req_ready_i) begin
            iss_q           <= StIdle;
            mem_req_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
